// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined 32x32 multiplier among N requesters.
// Optional counters: define MULT_ARB_STATS_EN to add stat_issued/stat_stall.

// Generic synchronous FIFO with occupancy count.
// Latency: push visible at head the cycle after the write.
// Backpressure: none internally; caller must never push when full or pop when empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdat,
  input  logic                       pop,
  output logic [W-1:0]               rdat,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  assign rdat  = mem[rd_ptr];
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// Round-robin arbiter feeding a shared multiplier, with tagged in-order responses.
// Latency: handshake in cycle t gives rsp_valid in cycle t+LAT+1.
// Backpressure: grants stop while in-flight plus queued results would exceed DEPTH.
module mult_share_arbiter #(
  parameter int N     = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int IDW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [63:0]       mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [63:0]       rsp_product
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);
  localparam int PW  = $clog2(N);
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(DEPTH+1);
  localparam int SW  = CW + $clog2(LAT+1) + 1;

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    product;
  } rsp_t;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_vld;
  logic [N-1:0]  grant_vec;
  logic [PW1-1:0] rr_nxt;
  tag_t          tag_q [LAT];
  logic [SW-1:0] inflight;
  logic [CW-1:0] occ;
  logic          credit;
  logic          fifo_empty;
  logic          rsp_pop;
  rsp_t          fifo_wdat;
  rsp_t          fifo_rdat;

  always_comb begin
    inflight = '0;
    for (int s = 0; s < LAT; s++) inflight = inflight + SW'(tag_q[s].v);
  end

  // Credit uses registered counts only, so a same-cycle pop frees nothing yet.
  assign credit = (inflight + SW'(occ)) < SW'(DEPTH);

  always_comb begin
    logic [PW1-1:0] sum;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    if (rst_n && credit) begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, rr_ptr} + PW1'(k);
        if (sum >= PW1'(N)) sum = sum - PW1'(N);
        if (!grant_vld && req_valid[sum[PW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = sum[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_vld) grant_vec[grant_idx] = 1'b1;
  end

  assign req_ready = grant_vec;
  assign mul_a     = grant_vld ? req_a[32*grant_idx +: 32] : 32'd0;
  assign mul_b     = grant_vld ? req_b[32*grant_idx +: 32] : 32'd0;

  always_comb begin
    rr_nxt = {1'b0, grant_idx} + PW1'(1);
    if (rr_nxt >= PW1'(N)) rr_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      if (grant_vld) rr_ptr <= rr_nxt[PW-1:0];
      tag_q[0] <= '{v: grant_vld, id: IDW'(grant_idx)};
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign fifo_wdat = '{id: tag_q[LAT-1].id, product: mul_p};
  assign rsp_pop   = rsp_valid & rsp_ready;

  sync_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_q[LAT-1].v),
    .wdat  (fifo_wdat),
    .pop   (rsp_pop),
    .rdat  (fifo_rdat),
    .empty (fifo_empty),
    .count (occ)
  );

  assign rsp_valid   = !fifo_empty;
  assign rsp_id      = fifo_rdat.id;
  assign rsp_product = fifo_rdat.product;

`ifdef MULT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant_vld && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !credit && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a registered multiplier model.
module tb_mult_share_arbiter;
  localparam int N = 4, LAT = 2, DEPTH = 4, IDW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [31:0]     mul_a, mul_b;
  logic [63:0]     mul_p;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic [63:0]     rsp_product;
`ifdef MULT_ARB_STATS_EN
  logic [31:0]     stat_issued, stat_stall;
`endif

  int total = 0;
  int bad = 0;

  mult_share_arbiter #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_p       (mul_p),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier wrapper model: LAT register stages, never reset.
  logic [63:0] mp [LAT];
  always_ff @(posedge clk) begin
    mp[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
  end
  assign mul_p = mp[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] exp_g;
  logic [3:0] bp_exp [7];
  int         dr_id  [4];
  int         dr_prod[4];

  initial begin
    bp_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    dr_id   = '{2, 3, 0, 1};
    dr_prod = '{30, 40, 10, 20};

    // Reset state with requests pending.
    req_valid = 4'hF;
    set_req(0, 32'd5, 32'd6);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
`ifdef MULT_ARB_STATS_EN
    chk("rst_issued", stat_issued, 0);
`endif
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Round robin across all requesters.
    for (int i = 0; i < N; i++) set_req(i, i + 1, 32'd10);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) req_valid = '0;
      #1;
      if (k < 5) begin
        exp_g = 4'b0001 << (k % 4);
        chk("rr_grant", req_ready, exp_g);
      end
      if (k >= 3 && k < 8) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, (k - 3) % 4);
        chk("rr_product", rsp_product, ((k - 3) % 4 + 1) * 10);
      end
      if (k == 8) chk("rr_empty", rsp_valid, 0);
      tick();
    end

    // Single request with all-ones operands (rr_ptr is 1, so search 1 then 2).
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    chk("single_mul_a", mul_a, 32'hFFFF_FFFF);
    tick();
    req_valid = '0;
    #1;
    chk("single_t1", rsp_valid, 0);
    tick();
    #1;
    chk("single_t2", rsp_valid, 0);
    tick();
    #1;
    chk("single_t3_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    chk("single_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
    tick();

    // Zero multiplicand from requester 0 (rr_ptr is 3, wraps to 0).
    set_req(0, 32'd0, 32'h1234_5678);
    req_valid = 4'b0001;
    #1;
    chk("zero_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    #1;
    chk("zero_valid", rsp_valid, 1);
    chk("zero_id", rsp_id, 0);
    chk("zero_product", rsp_product, 0);
    tick();
    #1;
    chk("zero_empty", rsp_valid, 0);

    // Backpressure: exactly DEPTH grants, then stall.
    for (int i = 0; i < N; i++) set_req(i, i + 1, 32'd10);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("bp_grant", req_ready, bp_exp[k]);
      tick();
    end

    // Full FIFO: one pop, then a grant the following cycle.
    rsp_ready = 1'b1;
    #1;
    chk("full_pop_ready", req_ready, 0);
    chk("full_head_id", rsp_id, 1);
    chk("full_head_product", rsp_product, 20);
`ifdef MULT_ARB_STATS_EN
    chk("stat_stall", stat_stall, 3);
    chk("stat_issued", stat_issued, 11);
`endif
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("resume_grant", req_ready, 4'b0010);
    chk("resume_head_id", rsp_id, 2);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("refull_ready", req_ready, 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("drain_valid", rsp_valid, 1);
      chk("drain_id", rsp_id, dr_id[j]);
      chk("drain_product", rsp_product, dr_prod[j]);
      tick();
    end
    #1;
    chk("drain_empty", rsp_valid, 0);

    // Reset with two requests in flight (rr_ptr is 2).
    set_req(2, 32'd7, 32'd3);
    req_valid = 4'b0100;
    #1;
    chk("mid_grant2", req_ready, 4'b0100);
    tick();
    set_req(3, 32'd9, 32'd9);
    req_valid = 4'b1000;
    #1;
    chk("mid_grant3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0001;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("mid_no_stale", rsp_valid, 0);
      tick();
    end
    set_req(1, 32'h0001_0000, 32'h0001_0000);
    req_valid = 4'b0010;
    #1;
    chk("post_rst_grant", req_ready, 4'b0010);
    chk("post_rst_mul_a", mul_a, 32'h0001_0000);
    tick();
    req_valid = '0;
    #1;
    chk("post_rst_t1", rsp_valid, 0);
    tick();
    #1;
    chk("post_rst_t2", rsp_valid, 0);
    tick();
    #1;
    chk("post_rst_valid", rsp_valid, 1);
    chk("post_rst_id", rsp_id, 1);
    chk("post_rst_product", rsp_product, 64'h0000_0001_0000_0000);
    tick();
    #1;
    chk("post_rst_empty", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
